// File: rtl/bus_arbiter_rr_if.sv
// Bus bundle between the round-robin arbiter and the terminal FIFOs.
// master: arbiter side; slave: FIFO side (input FIFO pop / output FIFO push).
interface bus_arbiter_rr_if #(
    parameter int unsigned width   = 16,
    parameter int unsigned drivers = 4
);
    localparam int unsigned GrantW = $clog2(drivers);

    logic [drivers-1:0]       pndng;
    logic [drivers*width-1:0] D_pop;
    logic [drivers-1:0]       pop;
    logic [drivers-1:0]       push;
    logic [width-1:0]         D_push;
    logic [GrantW-1:0]        grant;
    logic                     drop;

    modport master (
        input  pndng,
        input  D_pop,
        output pop,
        output push,
        output D_push,
        output grant,
        output drop
    );

    modport slave (
        output pndng,
        output D_pop,
        input  pop,
        input  push,
        input  D_push,
        input  grant,
        input  drop
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter/sequencer for the shared terminal bus.
// Each transfer takes three cycles: IDLE (arbitrate), POP (strobe source FIFO,
// capture packet), PUSH (strobe destination FIFO(s) or flag a drop).
module bus_arbiter_rr #(
    parameter int unsigned width     = 16,
    parameter int unsigned drivers   = 4,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input logic               clk,
    input logic               reset,
    bus_arbiter_rr_if.master  bus
);
    localparam int unsigned GrantW = $clog2(drivers);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StPop  = 2'd1;
    localparam logic [1:0] StPush = 2'd2;

    logic [1:0]         state_q,  state_d;
    logic [GrantW-1:0]  grant_q,  grant_d;
    logic [GrantW-1:0]  last_q,   last_d;
    logic [drivers-1:0] pop_q,    pop_d;
    logic [drivers-1:0] push_q,   push_d;
    logic [width-1:0]   d_push_q, d_push_d;
    logic               drop_q,   drop_d;

    logic               found;
    logic [GrantW-1:0]  next_idx;
    logic [width-1:0]   lane;
    logic [7:0]         dst_id;

    // Head packet of the granted terminal and its destination ID field.
    assign lane   = bus.D_pop[grant_q*width +: width];
    assign dst_id = lane[width-1 -: 8];

    // Round-robin search: first pending terminal starting at last+1, wrapping.
    always_comb begin
        int unsigned idx;
        found    = 1'b0;
        next_idx = '0;
        idx      = 0;
        for (int unsigned k = 1; k <= drivers; k++) begin
            idx = (32'(last_q) + k) % drivers;
            if (!found && bus.pndng[idx]) begin
                found    = 1'b1;
                next_idx = idx[GrantW-1:0];
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/POP/PUSH sequence.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        pop_d    = '0;
        push_d   = '0;
        d_push_d = d_push_q;
        drop_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d         = next_idx;
                    pop_d[next_idx] = 1'b1;
                    state_d         = StPop;
                end
            end
            StPop: begin
                // Push strobes are decided here so they are registered for the PUSH cycle.
                d_push_d = lane;
                last_d   = grant_q;
                state_d  = StPush;
                if (32'(dst_id) < drivers) begin
                    for (int unsigned i = 0; i < drivers; i++) begin
                        push_d[i] = (32'(dst_id) == i);
                    end
                end else if (dst_id == broadcast) begin
                    for (int unsigned i = 0; i < drivers; i++) begin
                        push_d[i] = (32'(grant_q) != i);
                    end
                end else begin
                    drop_d = 1'b1;
                end
            end
            StPush: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            last_q   <= GrantW'(drivers - 1);
            pop_q    <= '0;
            push_q   <= '0;
            d_push_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            pop_q    <= pop_d;
            push_q   <= push_d;
            d_push_q <= d_push_d;
            drop_q   <= drop_d;
        end
    end

    assign bus.pop    = pop_q;
    assign bus.push   = push_q;
    assign bus.D_push = d_push_q;
    assign bus.grant  = grant_q;
    assign bus.drop   = drop_q;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr (width=16, drivers=4).
module tb_bus_arbiter_rr;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    bus_arbiter_rr_if #(.width(16), .drivers(4)) bus ();

    bus_arbiter_rr #(
        .width    (16),
        .drivers  (4),
        .broadcast(8'hFF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [15:0] v);
        bus.D_pop[i*16 +: 16] = v;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        bus.pndng = 4'b1111;
        bus.D_pop = '0;

        // Reset held: requests ignored, outputs at reset values.
        tick();
        tick();
        check("rst_pop",    32'(bus.pop),    32'h0);
        check("rst_push",   32'(bus.push),   32'h0);
        check("rst_dpush",  32'(bus.D_push), 32'h0);
        check("rst_grant",  32'(bus.grant),  32'h0);
        check("rst_drop",   32'(bus.drop),   32'h0);

        bus.pndng = 4'b0000;
        reset     = 1'b1;
        tick();
        check("idle_pop",   32'(bus.pop),    32'h0);

        // Single unicast: terminal 1 -> terminal 2.
        set_lane(1, 16'h02A5);
        bus.pndng = 4'b0010;
        tick();
        check("uni_pop",    32'(bus.pop),    32'h2);
        check("uni_grant",  32'(bus.grant),  32'h1);
        check("uni_push0",  32'(bus.push),   32'h0);
        bus.pndng = 4'b0000;
        tick();
        check("uni_push",   32'(bus.push),   32'h4);
        check("uni_dpush",  32'(bus.D_push), 32'h02A5);
        check("uni_pop1",   32'(bus.pop),    32'h0);
        check("uni_drop",   32'(bus.drop),   32'h0);
        tick();
        check("uni_end",    32'(bus.push),   32'h0);
        check("uni_hold",   32'(bus.D_push), 32'h02A5);

        // Broadcast from terminal 2.
        set_lane(2, 16'hFF33);
        bus.pndng = 4'b0100;
        tick();
        check("bc_pop",     32'(bus.pop),    32'h4);
        check("bc_grant",   32'(bus.grant),  32'h2);
        bus.pndng = 4'b0000;
        tick();
        check("bc_push",    32'(bus.push),   32'hB);
        check("bc_dpush",   32'(bus.D_push), 32'hFF33);
        check("bc_drop",    32'(bus.drop),   32'h0);
        tick();

        // Invalid ID from terminal 0.
        set_lane(0, 16'h0711);
        bus.pndng = 4'b0001;
        tick();
        check("inv_pop",    32'(bus.pop),    32'h1);
        check("inv_grant",  32'(bus.grant),  32'h0);
        bus.pndng = 4'b0000;
        tick();
        check("inv_push",   32'(bus.push),   32'h0);
        check("inv_drop",   32'(bus.drop),   32'h1);
        tick();
        check("inv_drop1",  32'(bus.drop),   32'h0);

        // Fairness: reset so the search starts at 0, then all pending with ID 0.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) set_lane(i, 16'h0010 + 16'(i));
        bus.pndng = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            int g;
            g = s % 4;
            tick();
            check("rr_pop",   32'(bus.pop),    32'(1 << g));
            check("rr_grant", 32'(bus.grant),  32'(g));
            tick();
            check("rr_push",  32'(bus.push),   32'h1);
            check("rr_dpush", 32'(bus.D_push), 32'h0010 + 32'(g));
            if (s == 4) bus.pndng = 4'b0000;
            tick();
            check("rr_idle",  32'(bus.pop | bus.push), 32'h0);
        end

        // Reset mid-transfer: last=0, terminal 3 granted, reset during POP.
        set_lane(3, 16'h0099);
        bus.pndng = 4'b1000;
        tick();
        check("rm_pop",     32'(bus.pop),    32'h8);
        reset     = 1'b0;
        bus.pndng = 4'b0010;
        set_lane(1, 16'h0342);
        tick();
        check("rm_pop0",    32'(bus.pop),    32'h0);
        check("rm_push0",   32'(bus.push),   32'h0);
        check("rm_dpush0",  32'(bus.D_push), 32'h0);
        check("rm_grant0",  32'(bus.grant),  32'h0);
        reset = 1'b1;
        tick();
        check("rm_push1",   32'(bus.push),   32'h0);
        check("rm_pop1",    32'(bus.pop),    32'h2);
        check("rm_grant1",  32'(bus.grant),  32'h1);

        // Late request: terminal 3 rises during terminal 1's PUSH.
        bus.pndng = 4'b0000;
        tick();
        check("late_push",  32'(bus.push),   32'h8);
        check("late_dpush", 32'(bus.D_push), 32'h0342);
        bus.pndng = 4'b1000;
        tick();
        check("late_nopop", 32'(bus.pop),    32'h0);
        tick();
        check("late_pop",   32'(bus.pop),    32'h8);
        check("late_grant", 32'(bus.grant),  32'h3);
        tick();
        check("late_push3", 32'(bus.push),   32'h1);
        check("late_dp3",   32'(bus.D_push), 32'h0099);
        tick();

        // Wrap-around: only last (3) requests, re-granted.
        tick();
        check("wrap_pop",   32'(bus.pop),    32'h8);
        check("wrap_grant", 32'(bus.grant),  32'h3);
        bus.pndng = 4'b0000;
        tick();
        check("wrap_push",  32'(bus.push),   32'h1);
        tick();
        tick();
        check("quiet",      32'(bus.pop | bus.push), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Round-robin arbiter and sequencer for the shared 16-bit data bus between `drivers` terminal FIFOs. It grants one pending terminal at a time and pops that terminal's head packet {ID, payload}. It then pushes the packet into the FIFO of the terminal named by ID, or into every other terminal for the broadcast ID. It sits between the terminal input FIFOs (pop side) and the terminal output FIFOs (push side) and is the only master of the bus.

## Interface
Parameters:
- `width`, 16, packet width in bits; ID field is `[width-1:width-8]`, payload is `[width-9:0]`
- `drivers`, 4, number of terminals (2..16)
- `broadcast`, 8'hFF, ID value meaning "all terminals except the source"

Ports:
- `clk`  input  1  bus clock; all logic on rising edge
- `reset`  input  1  synchronous, active-low; sampled on rising `clk`
- `pndng`  input  `drivers`  bit i high: terminal i input FIFO non-empty
- `D_pop`  input  `drivers*width`  lane i = head packet of terminal i, valid while `pndng[i]`
- `pop`  output  `drivers`  one-hot pop strobe to input FIFOs
- `push`  output  `drivers`  push strobe to output FIFOs; one-hot, or multi-hot for broadcast
- `D_push`  output  `width`  packet driven to all output FIFOs
- `grant`  output  `$clog2(drivers)`  index of the terminal currently or last served
- `drop`  output  1  one-cycle pulse: packet discarded because its ID is invalid

## Operation
- FSM states are IDLE, POP, PUSH.
- IDLE:
  - If `pndng` is non-zero, select the first set bit searching from `last+1` upward, wrapping modulo `drivers`.
  - Register it in `grant` and go to POP. Otherwise stay in IDLE.
- POP:
  - `pop[grant]=1` for exactly this cycle.
  - At the closing edge, capture lane `D_pop[grant]` into `D_push`, update `last<=grant`, and go to PUSH.
- PUSH:
  - Destination `dst` = captured ID field.
  - If `dst < drivers`: `push[dst]=1`. `dst==grant` is legal and delivers back to the source.
  - If `dst==broadcast`: `push[i]=1` for every i except `grant`.
  - Otherwise: `push=0` and `drop=1`.
  - Always return to IDLE.
- `pndng` is sampled only in IDLE. Changes during POP/PUSH do not alter the current transfer.
- `D_push` holds its last captured value until the next POP capture.
- The arbiter has no back-pressure input. Output FIFO overflow is the FIFO's responsibility.
- Reset values: state IDLE, `last=drivers-1` (first search starts at terminal 0), `pop=0`, `push=0`, `D_push=0`, `grant=0`, `drop=0`.

## Timing
- Latency: `pndng` seen high at edge N (IDLE). `pop` is high in cycle N+1. `push`/`drop` is high in cycle N+2. Back in IDLE at N+3.
- Throughput: one packet per 3 cycles when requests are continuous.
- `pop`, `push`, `drop` are registered single-cycle pulses; never high two cycles in a row for the same packet.
- `pop` and `push` are never high in the same cycle.
- Round-robin fairness: with all `pndng` bits held high, the grant order is 0,1,2,3,0,… Any terminal waits at most `drivers-1` transfers.
- Wrap-around: with `last=drivers-1`, the search begins at 0. With only `last` requesting, `last` is re-granted.
- Reset mid-operation:
  - Reset low at any edge forces all outputs to their reset values on that edge.
  - A captured but unpushed packet is lost.
  - No `push` is issued after reset.
- Reset held low: `pndng` is ignored. The first grant can occur at the first edge with `reset` high.

## Test plan
- Single unicast: `pndng=4'b0010`, `D_pop` lane1=16'h02A5 -> `pop=4'b0010` in cycle N+1, `push=4'b0100` with `D_push=16'h02A5` in cycle N+2, `grant=1`.
- Fairness: all four `pndng` held high, each with ID 0 -> grants 0,1,2,3,0 on successive 3-cycle slots; each `pop` appears exactly once per round.
- Broadcast: terminal 2 sends 16'hFF33 -> `push=4'b1011`, `D_push=16'hFF33`, `drop=0`.
- Invalid ID: terminal 0 sends 16'h0711 with drivers=4 -> `pop=4'b0001`, then `push=0` and `drop=1` for one cycle.
- Reset mid-transfer: assert `reset=0` in the POP cycle -> next edge `pop=0`, `push=0`, `D_push=0`. After release, the first grant goes to the lowest pending terminal.
- Late request: `pndng[3]` rises during PUSH of terminal 1 -> terminal 3 is granted at the next IDLE edge, with no extra pop for terminal 1.
